dds_mod_sequencer: RTL and testbench
====================================

Name: dds_mod_sequencer

Overview:
- Modulation source placed directly upstream of the DDS core.
- Holds a programmable modulation waveform table (sine, triangle, ...) and steps through it at a programmable rate.
- Drives the DDS FreqCntrl input (FM) or AmplCntrl input (AM) cycle-accurately, so software does not have to rewrite control words per sample.
- Table is loaded through a write port shaped like the DDS LUT port.

Parameters:
- ModAddrWidth, 8, modulation table address width; table depth is 2**ModAddrWidth.
- SampleWidth, 16, signed modulation sample width.
- HoldWidth, 24, width of the per-sample hold counter.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; low freezes the sequencer.
- Mode  in  2  0 = off, 1 = FM, 2 = AM, 3 = off.
- Start  in  1  single-cycle start pulse.
- Stop  in  1  single-cycle abort pulse.
- Continuous  in  1  1 = wrap the table endlessly; 0 = one pass.
- SampleNum  in  ModAddrWidth+1  samples per pass; 0 or >2**ModAddrWidth means 2**ModAddrWidth.
- HoldCount  in  HoldWidth  clocks each sample is held; values <2 are treated as 2.
- FmShift  in  4  arithmetic right shift applied to the sample in FM.
- BaseFreq  in  32 signed  carrier frequency word.
- BaseAmpl  in  16 signed  carrier amplitude.
- LUTWe  in  1  table write strobe.
- LUTAddress  in  ModAddrWidth  table write address.
- LUTData  in  SampleWidth  table write data.
- FreqCntrl  out  32 signed  to DDS FreqCntrl.
- AmplCntrl  out  16 signed  to DDS AmplCntrlA.
- SampleIdx  out  ModAddrWidth  index of the sample currently driven.
- Busy  out  1  high in LOAD or RUN.
- Done  out  1  one-cycle pulse at the end of a one-shot pass.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; FreqCntrl=0, AmplCntrl=0, SampleIdx=0, Busy=0, Done=0; hold counter and index cleared. Table contents are not reset.
- Table: single write port and single read port, synchronous read with 1-cycle latency. A write and a read to the same address in one cycle returns the old data. Writes are accepted in any state and when en=0.
- IDLE: FreqCntrl<=BaseFreq and AmplCntrl<=BaseAmpl, registered with 1-cycle latency.
- IDLE to LOAD: on a clock edge where Start=1, en=1 and Mode is 1 or 2. Otherwise Start is ignored. Start is also ignored while Busy=1.
- LOAD: issue a read of address 0; Busy=1; go to RUN on the next edge.
- RUN, output timing: the registered outputs reflect sample 0 two edges after the Start edge.
- RUN, hold and prefetch: each sample is held exactly max(HoldCount,2) cycles. The next address is prefetched during the hold, so there are no gaps between samples. SampleIdx updates on the same edge as the outputs.
- FM (Mode=1): FreqCntrl = BaseFreq + signext32(sample >>> FmShift), with 32-bit two's-complement wrap. AmplCntrl = BaseAmpl.
- AM (Mode=2): AmplCntrl = sample. FreqCntrl = BaseFreq.
- End of pass (last sample, hold expired):
  - Continuous=1: wrap to index 0 seamlessly.
  - Continuous=0: go to IDLE, pulse Done for 1 cycle, outputs return to base values on that edge.
- Stop=1 in LOAD or RUN: go to IDLE on the next edge, no Done pulse, outputs return to base. Stop in IDLE is a no-op. Stop has priority over Start.
- en=0: state, counters, index and outputs are frozen; resume exactly where stopped when en returns high.
- Mode changes during RUN: take effect on the next output update. Mode set to 0 or 3 during RUN behaves as Stop.
- BaseFreq, BaseAmpl and FmShift are sampled at every output update, not latched at Start.
- Reset asserted mid-RUN: immediate IDLE with reset output values.

Test Plan:
- Reset, then load table[i]=i*256 for i=0..255, then Start with Mode=2, HoldCount=3, SampleNum=4, Continuous=0 -> AmplCntrl = 0x0000, 0x0100, 0x0200, 0x0300, each held 3 cycles; first value appears 2 edges after Start; Done pulses once; AmplCntrl returns to BaseAmpl=0x7FFF.
- FM with BaseFreq=30000, FmShift=2, table[0]=-32768, table[1]=32767, HoldCount=2, SampleNum=2, Continuous=1 -> FreqCntrl alternates 21808, 38191 every 2 cycles indefinitely; Done never asserts.
- BaseFreq=32'h7FFFFFFF, table[0]=4, FmShift=0 -> FreqCntrl=32'h80000003 (wrap, no saturation).
- HoldCount=0 with SampleNum=0 -> each sample held 2 cycles; all 256 samples played; Done pulses 512 cycles after sample 0 first appears.
- Stop asserted mid-pass, en=0 held for 10 cycles mid-sample, Start asserted while Busy -> Stop gives IDLE next edge with no Done; en=0 freezes SampleIdx and outputs exactly for 10 cycles; Start while Busy has no effect.
- LUTWe to the address being prefetched in the same cycle -> the old value is driven; the new value appears on the next pass; rst_n pulsed mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/dds_mod_sequencer.sv
// Modulation sequencer placed in front of a DDS core: plays a RAM-held waveform
// table into the carrier frequency word (FM) or the amplitude word (AM).
module dds_mod_sequencer #(
    parameter int ModAddrWidth = 8,
    parameter int SampleWidth  = 16,
    parameter int HoldWidth    = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              Mode,
    input  logic                    Start,
    input  logic                    Stop,
    input  logic                    Continuous,
    input  logic [ModAddrWidth:0]   SampleNum,
    input  logic [HoldWidth-1:0]    HoldCount,
    input  logic [3:0]              FmShift,
    input  logic signed [31:0]      BaseFreq,
    input  logic signed [15:0]      BaseAmpl,
    input  logic                    LUTWe,
    input  logic [ModAddrWidth-1:0] LUTAddress,
    input  logic [SampleWidth-1:0]  LUTData,
    output logic signed [31:0]      FreqCntrl,
    output logic signed [15:0]      AmplCntrl,
    output logic [ModAddrWidth-1:0] SampleIdx,
    output logic                    Busy,
    output logic                    Done
);
    localparam int Depth = 2 ** ModAddrWidth;
    localparam logic [ModAddrWidth:0] DepthCnt = {1'b1, {ModAddrWidth{1'b0}}};
    localparam logic [ModAddrWidth:0] IdxOne   = {{ModAddrWidth{1'b0}}, 1'b1};
    localparam logic [HoldWidth-1:0]  HoldOne  = {{(HoldWidth-1){1'b0}}, 1'b1};
    localparam logic [HoldWidth-1:0]  MinHold  = {{(HoldWidth-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
    state_t state_reg, state_next;

    logic [SampleWidth-1:0]  mem [Depth];
    logic [SampleWidth-1:0]  rd_data_reg;
    logic                    rd_en;
    logic [ModAddrWidth-1:0] rd_addr;

    logic [ModAddrWidth:0]   nxt_reg;   // index of the sample to be driven at the next update
    logic [HoldWidth-1:0]    hold_reg;  // clocks left before the next update; 0 means update now
    logic [ModAddrWidth-1:0] idx_reg;
    logic signed [31:0]      freq_reg;
    logic signed [15:0]      ampl_reg;
    logic                    done_reg;

    logic                    mode_ok, abort, update, end_pass, done_set;
    logic [ModAddrWidth:0]   count, nxt_inc, nxt_adv;
    logic [HoldWidth-1:0]    hold_len;
    logic signed [SampleWidth-1:0] sample, fm_off;
    logic signed [31:0]      fm_freq;

    assign mode_ok  = (Mode == 2'd1) || (Mode == 2'd2);
    assign abort    = Stop || !mode_ok;
    assign count    = (SampleNum == '0 || SampleNum > DepthCnt) ? DepthCnt : SampleNum;
    assign hold_len = (HoldCount < MinHold) ? MinHold : HoldCount;
    assign update   = (state_reg == RUN) && (hold_reg == '0);
    assign end_pass = update && (nxt_reg >= count);
    assign nxt_inc  = nxt_reg + IdxOne;
    assign nxt_adv  = (Continuous && nxt_inc >= count) ? '0 : nxt_inc;
    assign sample   = $signed(rd_data_reg);
    assign fm_off   = sample >>> FmShift;
    assign fm_freq  = BaseFreq + 32'(fm_off);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; en low freezes the whole sequencer
    always_comb begin
        state_next = state_reg;
        if (en) begin
            case (state_reg)
                IDLE:    if (Start && !Stop && mode_ok) state_next = LOAD;
                LOAD:    state_next = abort ? IDLE : RUN;
                RUN:     if (abort || end_pass) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: the single table read per sample lands one clock before its update
    always_comb begin
        Busy     = (state_reg != IDLE);
        rd_en    = 1'b0;
        rd_addr  = nxt_reg[ModAddrWidth-1:0];
        done_set = 1'b0;
        if (en) begin
            case (state_reg)
                LOAD: begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                end
                RUN: begin
                    rd_en    = (hold_reg == HoldOne);
                    done_set = !abort && end_pass;
                end
                default: ;
            endcase
        end
    end

    // Table: read-before-write, so a same-address write returns the old word
    always_ff @(posedge clk) begin
        if (LUTWe) mem[LUTAddress] <= LUTData;
        if (rd_en) rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_reg  <= '0;
            hold_reg <= '0;
            idx_reg  <= '0;
            freq_reg <= '0;
            ampl_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= done_set;
            if (en) begin
                if (state_reg != RUN || abort || end_pass) begin
                    freq_reg <= BaseFreq;
                    ampl_reg <= BaseAmpl;
                    nxt_reg  <= '0;
                    hold_reg <= '0;
                end else if (update) begin
                    freq_reg <= (Mode == 2'd1) ? fm_freq : BaseFreq;
                    ampl_reg <= (Mode == 2'd2) ? 16'(sample) : BaseAmpl;
                    idx_reg  <= nxt_reg[ModAddrWidth-1:0];
                    nxt_reg  <= nxt_adv;
                    hold_reg <= hold_len - HoldOne;
                end else begin
                    hold_reg <= hold_reg - HoldOne;
                end
            end
        end
    end

    assign FreqCntrl = freq_reg;
    assign AmplCntrl = ampl_reg;
    assign SampleIdx = idx_reg;
    assign Done      = done_reg;
endmodule

// File: tb/tb_dds_mod_sequencer.sv
// Bench for dds_mod_sequencer: directed scenarios followed by random traffic,
// all checked cycle by cycle against a sample-schedule reference model.
`timescale 1ns/1ps
module tb_dds_mod_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, Start, Stop, Continuous, LUTWe;
    logic [1:0]  Mode;
    logic [8:0]  SampleNum;
    logic [23:0] HoldCount;
    logic [3:0]  FmShift;
    logic signed [31:0] BaseFreq;
    logic signed [15:0] BaseAmpl;
    logic [7:0]  LUTAddress;
    logic [15:0] LUTData;
    logic signed [31:0] FreqCntrl;
    logic signed [15:0] AmplCntrl;
    logic [7:0]  SampleIdx;
    logic Busy, Done;

    dds_mod_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .Mode(Mode), .Start(Start), .Stop(Stop),
        .Continuous(Continuous), .SampleNum(SampleNum), .HoldCount(HoldCount),
        .FmShift(FmShift), .BaseFreq(BaseFreq), .BaseAmpl(BaseAmpl), .LUTWe(LUTWe),
        .LUTAddress(LUTAddress), .LUTData(LUTData), .FreqCntrl(FreqCntrl),
        .AmplCntrl(AmplCntrl), .SampleIdx(SampleIdx), .Busy(Busy), .Done(Done)
    );

    int total = 0;
    int bad = 0;
    int done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: shadow table plus the schedule "sample k is driven on the
    // (2 + k*H)-th enabled edge after Start", using the table as it stood before
    // the previous enabled edge (the prefetch).
    logic [15:0] tab  [256];
    logic [15:0] snap [256];
    bit m_run, m_done;
    int m_n;
    logic signed [31:0] m_freq;
    logic signed [15:0] m_ampl;
    logic [7:0] m_idx;

    task automatic model_reset();
        m_run = 0; m_n = 0; m_freq = '0; m_ampl = '0; m_idx = '0; m_done = 0;
    endtask

    function automatic int eff_cnt();
        return (SampleNum == 0 || SampleNum > 256) ? 256 : int'(SampleNum);
    endfunction

    task automatic model_step();
        int p, h, k, c, sv;
        bit mok;
        if (rst_n) begin
            m_done = 0;
            if (en) begin
                mok = (Mode == 2'd1 || Mode == 2'd2);
                if (!m_run) begin
                    m_freq = BaseFreq; m_ampl = BaseAmpl;
                    if (Start && !Stop && mok) begin m_run = 1; m_n = 0; end
                end else begin
                    m_n++;
                    if (Stop || !mok) begin
                        m_run = 0; m_freq = BaseFreq; m_ampl = BaseAmpl;
                    end else if (m_n == 1) begin
                        m_freq = BaseFreq; m_ampl = BaseAmpl;
                    end else begin
                        p = m_n - 2;
                        h = (HoldCount < 2) ? 2 : int'(HoldCount);
                        c = eff_cnt();
                        k = p / h;
                        if (p % h == 0) begin
                            if (!Continuous && k >= c) begin
                                m_run = 0; m_done = 1; m_freq = BaseFreq; m_ampl = BaseAmpl;
                            end else begin
                                sv = int'($signed(snap[k % c])) >>> FmShift;
                                m_idx  = 8'(k % c);
                                m_freq = (Mode == 2'd1) ? BaseFreq + sv : BaseFreq;
                                m_ampl = (Mode == 2'd2) ? $signed(snap[k % c]) : BaseAmpl;
                            end
                        end
                    end
                end
                snap = tab;
            end
        end
        if (LUTWe) tab[LUTAddress] = LUTData;
    endtask

    task automatic check_all();
        chk("freq", FreqCntrl, m_freq);
        chk("ampl", AmplCntrl, m_ampl);
        chk("idx",  SampleIdx, m_idx);
        chk("busy", Busy, m_run);
        chk("done", Done, m_done);
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk);
        if (Done) done_seen++;
        check_all();
    endtask

    task automatic start_pulse();
        Start = 1'b1; cyc(); Start = 1'b0;
    endtask

    task automatic write_tab(input int a, input logic [15:0] d);
        LUTWe = 1'b1; LUTAddress = 8'(a); LUTData = d; cyc(); LUTWe = 1'b0;
    endtask

    initial begin
        int d0, w;
        for (int i = 0; i < 256; i++) begin tab[i] = '0; snap[i] = '0; end
        rst_n = 1'b0; en = 1'b1; Start = 1'b0; Stop = 1'b0; Continuous = 1'b0; LUTWe = 1'b0;
        Mode = 2'd0; SampleNum = '0; HoldCount = '0; FmShift = '0;
        BaseFreq = 32'sd0; BaseAmpl = 16'sh7FFF; LUTAddress = '0; LUTData = '0;
        model_reset();
        @(negedge clk);
        check_all();
        cyc();
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 256; i++) write_tab(i, 16'(i * 256));

        // One-shot AM pass over four samples
        Mode = 2'd2; HoldCount = 24'd3; SampleNum = 9'd4; Continuous = 1'b0;
        d0 = done_seen;
        start_pulse();
        repeat (20) cyc();
        chk("t1_done_count", done_seen - d0, 1);
        chk("t1_back_to_base", AmplCntrl, 16'h7FFF);

        // Continuous FM alternating two samples
        write_tab(0, 16'h8000);
        write_tab(1, 16'h7FFF);
        BaseFreq = 32'sd30000; FmShift = 4'd2; Mode = 2'd1;
        HoldCount = 24'd2; SampleNum = 9'd2; Continuous = 1'b1;
        d0 = done_seen;
        start_pulse();
        cyc(); cyc();
        chk("t2_low", FreqCntrl, 32'd21808);
        cyc(); cyc();
        chk("t2_high", FreqCntrl, 32'd38191);
        repeat (40) cyc();
        chk("t2_no_done", done_seen - d0, 0);
        Stop = 1'b1; cyc(); Stop = 1'b0;

        // FM wraps rather than saturating
        BaseFreq = 32'h7FFFFFFF; FmShift = 4'd0;
        write_tab(0, 16'd4);
        SampleNum = 9'd1; Continuous = 1'b0;
        start_pulse();
        cyc(); cyc();
        chk("t3_wrap", FreqCntrl, 32'h80000003);
        repeat (5) cyc();

        // Minimum hold over the full table
        BaseFreq = 32'sd1000; Mode = 2'd2; HoldCount = 24'd0; SampleNum = 9'd0;
        start_pulse();
        cyc(); cyc();
        w = 0;
        do begin cyc(); w++; end while (!Done && w < 1000);
        chk("t4_done_latency", w, 512);
        cyc();

        // Freeze, start while busy, stop mid-pass
        HoldCount = 24'd5; SampleNum = 9'd8;
        d0 = done_seen;
        start_pulse();
        repeat (9) cyc();
        en = 1'b0;
        repeat (10) cyc();
        en = 1'b1;
        start_pulse();
        repeat (6) cyc();
        Stop = 1'b1; cyc(); Stop = 1'b0;
        chk("t5_stop_idle", Busy, 1'b0);
        repeat (3) cyc();
        chk("t5_no_done", done_seen - d0, 0);

        // Write racing the prefetch of sample 2, then reset mid-run
        HoldCount = 24'd4; SampleNum = 9'd4; Continuous = 1'b1;
        start_pulse();
        repeat (8) cyc();
        write_tab(2, 16'h1234);
        cyc();
        chk("t6_old_word", AmplCntrl, 16'h0200);
        repeat (16) cyc();
        chk("t6_new_word", AmplCntrl, 16'h1234);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Random traffic
        Mode = 2'd2; Continuous = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(15) != 0);
            LUTWe = ($urandom_range(3) == 0);
            LUTAddress = 8'($urandom);
            LUTData = 16'($urandom);
            Start = ($urandom_range(9) == 0);
            Stop = ($urandom_range(199) == 0);
            if ($urandom_range(99) == 0)
                Mode = ($urandom_range(7) == 0) ? 2'($urandom) : 2'($urandom_range(2, 1));
            if ($urandom_range(49) == 0) begin
                BaseFreq = $urandom; BaseAmpl = 16'($urandom); FmShift = 4'($urandom);
            end
            if (!m_run) begin
                HoldCount = 24'($urandom_range(5));
                SampleNum = ($urandom_range(9) == 0) ? 9'($urandom) : 9'($urandom_range(12));
                Continuous = ($urandom_range(3) == 0);
            end
            cyc();
        end
        Start = 1'b0; Stop = 1'b0; LUTWe = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
